// File: rtl/head_module_pkg.sv
// Shared constants for the vending head: prices, reset stock, status codes and 7-segment patterns.
package head_module_pkg;
  localparam int NUM_PROD = 8;
  localparam logic [3:0] STOCK_RST = 4'd5;
  localparam logic [6:0] REV_MAX = 7'd99;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SOLD     = 3'd1,
    ST_NO_MONEY = 3'd2,
    ST_NO_STOCK = 3'd3,
    ST_REVENUE  = 3'd4,
    ST_SUPPLY   = 3'd5,
    ST_CONFLICT = 3'd6
  } status_t;

  function automatic logic [3:0] price(input logic [2:0] p);
    case (p)
      3'd0: price = 4'd3;
      3'd1: price = 4'd4;
      3'd2: price = 4'd5;
      3'd3: price = 4'd7;
      3'd4: price = 4'd8;
      3'd5: price = 4'd10;
      3'd6: price = 4'd12;
      default: price = 4'd15;
    endcase
  endfunction

  // Segment order a=bit0 .. g=bit6, active high; non-decimal codes blank.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0: digit_seg = 7'b0111111;
      4'd1: digit_seg = 7'b0000110;
      4'd2: digit_seg = 7'b1011011;
      4'd3: digit_seg = 7'b1001111;
      4'd4: digit_seg = 7'b1100110;
      4'd5: digit_seg = 7'b1101101;
      4'd6: digit_seg = 7'b1111101;
      4'd7: digit_seg = 7'b0000111;
      4'd8: digit_seg = 7'b1111111;
      4'd9: digit_seg = 7'b1101111;
      default: digit_seg = 7'b0000000;
    endcase
  endfunction
endpackage

// File: rtl/head_module_seg7_decoder.sv
// 4-bit decimal digit to active-high 7-segment pattern.
module seg7_decoder
  import head_module_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = digit_seg(digit);
endmodule

// File: rtl/head_module.sv
// Vending head: edge-triggered customer/owner actions, per-product stock, revenue and 3-digit display.
// Optional REVENUE_CLEAR_EN: an owner money readout also clears revenue.
module head_module
  import head_module_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       costumer_mode,
  input  logic       owner_money_mode,
  input  logic       owner_supply_mode,
  input  logic [2:0] product,
  input  logic [3:0] costumer_money,
  input  logic [3:0] quantitiy,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3
);
  logic [2:0] modes, prev, armed, req;
  logic       multi;
  logic [NUM_PROD-1:0][3:0] stock;
  logic [6:0] revenue, value;
  status_t    status;

  logic [3:0] price_sel, cur_stock, change, sup_next;
  logic [7:0] rev_sum;
  logic [6:0] rev_next;
  logic [4:0] sup_sum;

  assign modes = {owner_supply_mode, owner_money_mode, costumer_mode};
  // armed blocks a level held across reset until it has been seen low once
  assign req   = modes & ~prev & armed;
  assign multi = (modes[0] & modes[1]) | (modes[0] & modes[2]) | (modes[1] & modes[2]);

  assign price_sel = price(product);
  assign cur_stock = stock[product];
  assign change    = costumer_money - price_sel;
  assign rev_sum   = {1'b0, revenue} + {4'b0, price_sel};
  assign rev_next  = (rev_sum > {1'b0, REV_MAX}) ? REV_MAX : rev_sum[6:0];
  assign sup_sum   = {1'b0, cur_stock} + {1'b0, quantitiy};
  assign sup_next  = sup_sum[4] ? 4'd15 : sup_sum[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stock   <= {NUM_PROD{STOCK_RST}};
      revenue <= '0;
      prev    <= '0;
      armed   <= ~modes;
      status  <= ST_IDLE;
      value   <= '0;
    end else begin
      prev  <= modes;
      armed <= armed | ~modes;
      if (|req) begin
        if (multi) begin
          status <= ST_CONFLICT;
          value  <= '0;
        end else if (req[0]) begin
          if (cur_stock == 4'd0) begin
            status <= ST_NO_STOCK;
            value  <= {3'b0, costumer_money};
          end else if (costumer_money < price_sel) begin
            status <= ST_NO_MONEY;
            value  <= {3'b0, costumer_money};
          end else begin
            stock[product] <= cur_stock - 4'd1;
            revenue        <= rev_next;
            status         <= ST_SOLD;
            value          <= {3'b0, change};
          end
        end else if (req[1]) begin
          status <= ST_REVENUE;
          value  <= revenue;
`ifdef REVENUE_CLEAR_EN
          revenue <= '0;
`else
          revenue <= revenue;
`endif
        end else begin
          stock[product] <= sup_next;
          status         <= ST_SUPPLY;
          value          <= {3'b0, sup_next};
        end
      end
    end
  end

  logic [2:0][3:0] digits;
  logic [2:0][6:0] segs;
  assign digits[2] = {1'b0, status};
  assign digits[1] = 4'(value / 7'd10);
  assign digits[0] = 4'(value % 7'd10);

  for (genvar i = 0; i < 3; i++) begin : g_dec
    seg7_decoder u_dec (.digit(digits[i]), .seg(segs[i]));
  end

  assign seg1 = segs[2];
  assign seg2 = segs[1];
  assign seg3 = segs[0];
endmodule

// File: tb/tb_head_module.sv
// Randomized + directed bench for head_module against a behavioural vending model.
module tb_head_module;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       costumer_mode = 1'b0, owner_money_mode = 1'b0, owner_supply_mode = 1'b0;
  logic [2:0] product = '0;
  logic [3:0] costumer_money = '0, quantitiy = '0;
  logic [6:0] seg1, seg2, seg3;

  head_module dut (
    .clk(clk), .rst(rst),
    .costumer_mode(costumer_mode), .owner_money_mode(owner_money_mode),
    .owner_supply_mode(owner_supply_mode), .product(product),
    .costumer_money(costumer_money), .quantitiy(quantitiy),
    .seg1(seg1), .seg2(seg2), .seg3(seg3)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                      7'b1111111, 7'b1101111};
  localparam int PRICE [8] = '{3, 4, 5, 7, 8, 10, 12, 15};

  int n_vec = 0, n_err = 0;
  int m_stock [8];
  int m_rev = 0, m_st = 0, m_val = 0;
  bit m_last [3];   // level seen on the previous edge
  bit m_ok   [3];   // level has been observed low since reset

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Reference: what one clock edge does to the machine, given the inputs now applied.
  task automatic model_edge();
    bit lvl [3];
    int fresh, high;
    lvl[0] = costumer_mode; lvl[1] = owner_money_mode; lvl[2] = owner_supply_mode;
    if (rst) begin
      foreach (m_stock[i]) m_stock[i] = 5;
      m_rev = 0; m_st = 0; m_val = 0;
      for (int k = 0; k < 3; k++) begin m_last[k] = 0; m_ok[k] = !lvl[k]; end
      return;
    end
    fresh = 0; high = 0;
    for (int k = 0; k < 3; k++) begin
      if (lvl[k] && !m_last[k] && m_ok[k]) fresh = fresh | (1 << k);
      if (lvl[k]) high++;
    end
    if (fresh != 0) begin
      if (high > 1) begin
        m_st = 6; m_val = 0;
      end else if (fresh == 1) begin
        if (m_stock[product] == 0) begin m_st = 3; m_val = costumer_money; end
        else if (costumer_money < PRICE[product]) begin m_st = 2; m_val = costumer_money; end
        else begin
          m_stock[product]--;
          m_rev = (m_rev + PRICE[product] > 99) ? 99 : m_rev + PRICE[product];
          m_st = 1; m_val = costumer_money - PRICE[product];
        end
      end else if (fresh == 2) begin
        m_st = 4; m_val = m_rev;
`ifdef REVENUE_CLEAR_EN
        m_rev = 0;
`endif
      end else begin
        m_stock[product] = (m_stock[product] + quantitiy > 15) ? 15 : m_stock[product] + quantitiy;
        m_st = 5; m_val = m_stock[product];
      end
    end
    for (int k = 0; k < 3; k++) begin
      m_last[k] = lvl[k];
      if (!lvl[k]) m_ok[k] = 1;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit o, input bit s,
                      input int p, input int m, input int q);
    @(negedge clk);
    rst = r; costumer_mode = c; owner_money_mode = o; owner_supply_mode = s;
    product = 3'(p); costumer_money = 4'(m); quantitiy = 4'(q);
    @(posedge clk);
    model_edge();
    #1;
    chk("status", seg1, PAT[m_st]);
    chk("tens",   seg2, PAT[m_val / 10]);
    chk("units",  seg3, PAT[m_val % 10]);
  endtask

  task automatic press(input bit c, input bit o, input bit s, input int p, input int m, input int q);
    step(0, c, o, s, p, m, q);
    step(0, 0, 0, 0, p, m, q);
  endtask

  task automatic show(input string tag, input int st, input int v);
    chk({tag, "_s"}, seg1, PAT[st]);
    chk({tag, "_t"}, seg2, PAT[v / 10]);
    chk({tag, "_u"}, seg3, PAT[v % 10]);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    show("reset", 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 2, 12, 0);   show("buy_p2", 1, 7);
    step(0, 0, 0, 0, 2, 12, 0);
    press(0, 0, 1, 2, 0, 0);      show("stock_p2", 5, 4);
    step(0, 0, 1, 0, 0, 0, 0);    show("rev1", 4, 5);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
`ifdef REVENUE_CLEAR_EN
    show("rev2", 4, 0);
`else
    show("rev2", 4, 5);
`endif
    step(0, 0, 0, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0, 2);      show("sup_p0", 5, 7);
    press(0, 0, 1, 0, 0, 15);     show("sup_sat", 5, 15);
    press(1, 0, 0, 7, 14, 0);     show("short_p7", 2, 14);
    press(1, 0, 0, 7, 15, 0);     show("exact_p7", 1, 0);
    press(0, 0, 1, 7, 0, 0);      show("stock_p7", 5, 4);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) press(1, 0, 0, 1, 15, 0);
    show("buy5", 1, 11);
    press(1, 0, 0, 1, 15, 0);     show("empty_p1", 3, 15);
    press(0, 0, 1, 1, 0, 0);      show("p1_zero", 5, 0);
    press(0, 0, 1, 1, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 1, 9, 0);
    press(0, 0, 1, 1, 0, 0);      show("held_once", 5, 2);

    step(0, 1, 0, 1, 1, 9, 4);    show("conflict", 6, 0);
    step(0, 0, 0, 0, 1, 9, 4);
    press(0, 0, 1, 1, 0, 0);      show("conf_nochg", 5, 2);

    step(1, 1, 0, 0, 3, 15, 0);
    step(0, 1, 0, 0, 3, 15, 0);
    step(0, 1, 0, 0, 3, 15, 0);   show("held_rst", 0, 0);
    step(0, 0, 0, 0, 3, 15, 0);
    step(0, 1, 0, 0, 3, 15, 0);   show("rearmed", 1, 8);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 15),
           $urandom_range(0, 15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
